// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the 4-way bus arbiter: requester count, select width
// and the two-state sequencer encoding.
package bus_arbiter4_pkg;

    localparam int NUM_REQ  = 4;
    localparam int SEL_BITS = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/basicmux.sv
// Single-bit 2:1 multiplexer, the leaf cell of the bus data mux tree.
module basicmux (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder with enable; output is all zeros when disabled.
module decoder2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request bit scanning upward
// from start with wrap-around; found is 0 when no request is set.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the closest hit to start is kept.
    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        cand  = start;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter and sequencer for a 4-way shared bus with bounded hold
// time; drives registered one-hot grant/select and the muxed bus data.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int MAX_HOLD  = 4,
    parameter int HOLD_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATAWIDTH-1:0]  data0,
    input  logic [DATAWIDTH-1:0]  data1,
    input  logic [DATAWIDTH-1:0]  data2,
    input  logic [DATAWIDTH-1:0]  data3,
    output logic [NUM_REQ-1:0]    grant,
    output logic [SEL_BITS-1:0]   select,
    output logic                  bus_valid,
    output logic [DATAWIDTH-1:0]  bus_data
);

    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(MAX_HOLD - 1);

    arb_state_t           state, next_state;
    logic [SEL_BITS-1:0]  last, last_next, select_next, start;
    logic [HOLD_BITS-1:0] hold_cnt, hold_next;
    logic [NUM_REQ-1:0]   others, pick_req, grant_dec;
    logic                 pick_found;
    logic [SEL_BITS-1:0]  pick_idx;

    assign others = req & ~grant;

    // From IDLE the scan starts after the last owner; while granted it starts
    // after the current owner and only considers the waiting requesters.
    always_comb begin
        pick_req = req;
        start    = last + 2'd1;
        if (state == ST_GRANT) begin
            pick_req = others;
            start    = select + 2'd1;
        end
    end

    rr_pick u_pick (
        .req   (pick_req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        next_state  = state;
        select_next = select;
        last_next   = last;
        hold_next   = hold_cnt;
        case (state)
            ST_IDLE: begin
                select_next = 2'd0;
                if (pick_found) begin
                    next_state  = ST_GRANT;
                    select_next = pick_idx;
                    hold_next   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[select]) begin
                    last_next = select;
                    hold_next = '0;
                    if (pick_found) begin
                        select_next = pick_idx;
                    end else begin
                        next_state  = ST_IDLE;
                        select_next = 2'd0;
                    end
                end else if (others != '0 && hold_cnt == HOLD_LAST) begin
                    last_next   = select;
                    select_next = pick_idx;
                    hold_next   = '0;
                end else if (others != '0) begin
                    hold_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
                end else begin
                    hold_next = '0;
                end
            end
            default: begin
                next_state  = ST_IDLE;
                select_next = 2'd0;
            end
        endcase
    end

    decoder2to4 u_dec (
        .sel (select_next),
        .en  (next_state == ST_GRANT),
        .y   (grant_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            select    <= '0;
            last      <= 2'd3;
            hold_cnt  <= '0;
            bus_valid <= 1'b0;
        end else begin
            state     <= next_state;
            grant     <= grant_dec;
            select    <= select_next;
            last      <= last_next;
            hold_cnt  <= hold_next;
            bus_valid <= (next_state == ST_GRANT);
        end
    end

    // Two-level mux tree per bit, gated so the bus reads zero when idle.
    for (genvar b = 0; b < DATAWIDTH; b++) begin : g_bit
        logic lo, hi, y;
        basicmux u_lo  (.a(data0[b]), .b(data1[b]), .s(select[0]), .y(lo));
        basicmux u_hi  (.a(data2[b]), .b(data3[b]), .s(select[0]), .y(hi));
        basicmux u_top (.a(lo),       .b(hi),       .s(select[1]), .y(y));
        assign bus_data[b] = y & bus_valid;
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: directed scenarios plus randomized
// traffic compared each cycle against an integer-level round-robin model.
module tb_bus_arbiter4;

    localparam int DW = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    req;
    logic [DW-1:0] data0, data1, data2, data3;
    logic [3:0]    grant;
    logic [1:0]    select;
    logic          bus_valid;
    logic [DW-1:0] bus_data;

    int compared   = 0;
    int mismatched = 0;

    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;

    always #5 clk = ~clk;

    bus_arbiter4 #(.DATAWIDTH(DW), .MAX_HOLD(MH), .HOLD_BITS(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .grant     (grant),
        .select    (select),
        .bus_valid (bus_valid),
        .bus_data  (bus_data)
    );

    function automatic int rrScan(logic [3:0] r, int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    // Reference model: owner index or -1, updated once per clock edge.
    task automatic modelStep(input logic [3:0] r, input logic rn);
        logic [3:0] oth;
        if (!rn) begin
            m_owner = -1; m_last = 3; m_hold = 0;
        end else if (m_owner < 0) begin
            m_owner = rrScan(r, (m_last + 1) % 4);
            m_hold  = 0;
        end else begin
            oth = r & ~(4'b0001 << m_owner);
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = rrScan(oth, (m_owner + 1) % 4);
                m_hold  = 0;
            end else if (oth != 0 && m_hold == MH - 1) begin
                m_last  = m_owner;
                m_owner = rrScan(oth, (m_owner + 1) % 4);
                m_hold  = 0;
            end else if (oth != 0) begin
                m_hold = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
            end else begin
                m_hold = 0;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [DW-1:0] exp_data;
        logic [DW-1:0] words [4];
        words = '{data0, data1, data2, data3};
        exp_data = (m_owner < 0) ? '0 : words[m_owner];
        checkValue({tag, "_grant"},  32'(grant),     (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        checkValue({tag, "_select"}, 32'(select),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
        checkValue({tag, "_valid"},  32'(bus_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        checkValue({tag, "_data"},   32'(bus_data),  32'(exp_data));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check #1 later.
    task automatic applyStimulus(input logic [3:0] r, input logic rn, input string tag);
        req     = r;
        reset_n = rn;
        data0   = DW'($urandom);
        data1   = DW'($urandom);
        data2   = DW'($urandom);
        data3   = DW'($urandom);
        @(posedge clk);
        modelStep(r, rn);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        req = '0; reset_n = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;

        $display("[TB] reset");
        applyStimulus(4'b0000, 1'b0, "reset");
        applyStimulus(4'b0000, 1'b0, "reset");
        checkValue("reset_grant_const", 32'(grant), 32'd0);
        checkValue("reset_valid_const", 32'(bus_valid), 32'd0);

        $display("[TB] test1 first grant");
        applyStimulus(4'b0101, 1'b1, "t1");
        checkValue("t1_grant_const", 32'(grant), 32'b0001);
        checkValue("t1_data_const", 32'(bus_data), 32'(data0));

        $display("[TB] test2 direct handover");
        applyStimulus(4'b0100, 1'b1, "t2");
        checkValue("t2_grant_const", 32'(grant), 32'b0100);

        $display("[TB] test3 forced rotation");
        applyStimulus(4'b0000, 1'b0, "t3_rst");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(4'b1111, 1'b1, "t3");
            checkValue("t3_order", 32'(grant), 32'(1 << ((k / 4) % 4)));
        end

        $display("[TB] test4 lone requester");
        applyStimulus(4'b0000, 1'b0, "t4_rst");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(4'b0010, 1'b1, "t4");
            checkValue("t4_grant_const", 32'(grant), 32'b0010);
            checkValue("t4_hold", 32'(dut.hold_cnt), 32'd0);
        end

        $display("[TB] test5 reset mid-grant");
        applyStimulus(4'b0000, 1'b0, "t5_rst");
        for (int k = 0; k < 6; k++) applyStimulus(4'b1111, 1'b1, "t5_run");
        applyStimulus(4'b1111, 1'b0, "t5_hit");
        checkValue("t5_grant_zero", 32'(grant), 32'd0);
        checkValue("t5_select_zero", 32'(select), 32'd0);
        applyStimulus(4'b1111, 1'b1, "t5_rel");
        checkValue("t5_regrant", 32'(grant), 32'b0001);

        $display("[TB] test6 wrap priority");
        applyStimulus(4'b0000, 1'b0, "t6_rst");
        applyStimulus(4'b1001, 1'b1, "t6_a");
        checkValue("t6_first", 32'(grant), 32'b0001);
        applyStimulus(4'b1000, 1'b1, "t6_b");
        checkValue("t6_second", 32'(grant), 32'b1000);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 49) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
